xgmii_66b_decode: RTL

- Receive-side 64b/66b block decoder, the mirror of the 64b/66b transmit encoder.
- Accepts 32-bit half-blocks with a 2-bit sync header from the GTX RX gearbox at 312.5 MHz (156.25*2).
- Optionally descrambles the payload, reassembles 64-bit blocks, and decodes them per IEEE 802.3 Clause 49 into XGMII 64-bit data/8-bit control.
- One XGMII word is produced every two clocks; the output feeds the XGMII RX side of the MAC.

---
 rtl/xgmii_66b_pkg.sv | 60 ++++++
 rtl/descrambler_58_32.sv | 22 ++
 rtl/xgmii_66b_decode.sv | 91 +++++++++
 3 files changed

// File: rtl/xgmii_66b_pkg.sv
// xgmii_66b_pkg: shared 64b/66b sync header, block type, XGMII character and control-code constants
package xgmii_66b_pkg;
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;
  localparam logic [7:0] BT_C8    = 8'h1E;
  localparam logic [7:0] BT_C4_O4 = 8'h2D;
  localparam logic [7:0] BT_C4_S4 = 8'h33;
  localparam logic [7:0] BT_O0_S4 = 8'h66;
  localparam logic [7:0] BT_O0_O4 = 8'h55;
  localparam logic [7:0] BT_S0    = 8'h78;
  localparam logic [7:0] BT_O0_C4 = 8'h4B;
  localparam logic [7:0] BT_T0    = 8'h87;
  localparam logic [7:0] BT_T1    = 8'h99;
  localparam logic [7:0] BT_T2    = 8'hAA;
  localparam logic [7:0] BT_T3    = 8'hB4;
  localparam logic [7:0] BT_T4    = 8'hCC;
  localparam logic [7:0] BT_T5    = 8'hD2;
  localparam logic [7:0] BT_T6    = 8'hE1;
  localparam logic [7:0] BT_T7    = 8'hFF;
  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERROR = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;
  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_ERROR = 7'h1E;
  localparam logic [63:0] XG_LF_W = 64'h0100009C_0100009C;
  typedef enum logic {WAIT_FIRST, WAIT_SECOND} dec_state_e;
  typedef struct packed {
    logic [7:0] c;
    logic [7:0] o;
    logic [7:0] s;
    logic [7:0] t;
    logic       sh;
    logic       ok;
  } blk_fmt_t;
  function automatic blk_fmt_t blk_fmt(input logic [7:0] bt);
    blk_fmt_t f;
    f = '{c: 8'h00, o: 8'h00, s: 8'h00, t: 8'h00, sh: 1'b0, ok: 1'b1};
    case (bt)
      BT_C8:    f.c = 8'hFF;
      BT_C4_O4: begin f.c = 8'h0F; f.o = 8'h10; end
      BT_C4_S4: begin f.c = 8'h0F; f.s = 8'h10; end
      BT_O0_S4: begin f.o = 8'h01; f.s = 8'h10; end
      BT_O0_O4: f.o = 8'h11;
      BT_S0:    f.s = 8'h01;
      BT_O0_C4: begin f.o = 8'h01; f.c = 8'hF0; end
      BT_T0:    begin f.t = 8'h01; f.c = 8'hFE; f.sh = 1'b1; end
      BT_T1:    begin f.t = 8'h02; f.c = 8'hFC; f.sh = 1'b1; end
      BT_T2:    begin f.t = 8'h04; f.c = 8'hF8; f.sh = 1'b1; end
      BT_T3:    begin f.t = 8'h08; f.c = 8'hF0; f.sh = 1'b1; end
      BT_T4:    begin f.t = 8'h10; f.c = 8'hE0; f.sh = 1'b1; end
      BT_T5:    begin f.t = 8'h20; f.c = 8'hC0; f.sh = 1'b1; end
      BT_T6:    begin f.t = 8'h40; f.c = 8'h80; f.sh = 1'b1; end
      BT_T7:    begin f.t = 8'h80; f.sh = 1'b1; end
      default:  f.ok = 1'b0;
    endcase
    return f;
  endfunction
endpackage

// File: rtl/descrambler_58_32.sv
// descrambler_58_32: x^58+x^39+1 self-synchronizing descrambler, 32 bits per enabled cycle, LSB first
module descrambler_58_32 (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  logic [57:0] s_q, s_d, s_v;
  always_comb begin
    s_v = s_q;
    data_o = '0;
    for (int i = 0; i < 32; i++) begin
      data_o[i] = data_i[i] ^ s_v[38] ^ s_v[57];
      s_v = {s_v[56:0], data_i[i]};
    end
    s_d = en_i ? s_v : s_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) s_q <= '0;
    else s_q <= s_d;
endmodule

// File: rtl/xgmii_66b_decode.sv
// xgmii_66b_decode: 64b/66b receive block decoder from 32-bit half-blocks to XGMII 64-bit data/control
module xgmii_66b_decode
  import xgmii_66b_pkg::*;
#(
  parameter bit          DESCRAMBLE_EN = 1'b1,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [31:0]          decode_data_i,
  input  logic [1:0]           decode_head_i,
  input  logic                 decode_head_vld_i,
  input  logic                 decode_data_vld_i,
  input  logic                 block_lock_i,
  output logic [63:0]          xgmii_rxd_o,
  output logic [7:0]           xgmii_rxc_o,
  output logic                 xgmii_rxd_vld_o,
  output logic                 decode_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  logic [31:0] desc, pd, half_q, half_d;
  logic [1:0] head_q, head_d;
  dec_state_e state_q, state_d;
  logic [63:0] rxd_q, rxd_d, pay, dsh, ctl_rxd, dec_rxd;
  logic [7:0] rxc_q, rxc_d, ctl_rxc, dec_rxc, bad_cc;
  logic vld_q, vld_d, err_q, err_d, dec_err, wf, first, second;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  blk_fmt_t fmt;
  descrambler_58_32 u_desc (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (decode_data_vld_i),
    .data_i  (decode_data_i),
    .data_o  (desc)
  );
  assign pd = DESCRAMBLE_EN ? desc : decode_data_i;
  always_comb begin
    pay = {pd, half_q};
    fmt = blk_fmt(pay[7:0]);
    dsh = fmt.sh ? {8'h00, pay[63:8]} : pay;
    ctl_rxd = '0;
    bad_cc = '0;
    for (int k = 0; k < 8; k++) begin
      bad_cc[k] = fmt.c[k] && pay[8+7*k +: 7] != CC_IDLE && pay[8+7*k +: 7] != CC_ERROR;
      ctl_rxd[8*k +: 8] = fmt.c[k] ? (pay[8+7*k +: 7] == CC_IDLE ? XG_IDLE : XG_ERROR) :
                          fmt.o[k] ? XG_SEQ : fmt.s[k] ? XG_START : fmt.t[k] ? XG_TERM : dsh[8*k +: 8];
    end
    ctl_rxc = fmt.c | fmt.o | fmt.s | fmt.t;
    dec_err = head_q == SH_CTRL ? (!fmt.ok || |bad_cc) : head_q != SH_DATA;
    dec_rxd = dec_err ? {8{XG_ERROR}} : head_q == SH_DATA ? pay : ctl_rxd;
    dec_rxc = dec_err ? 8'hFF : head_q == SH_DATA ? 8'h00 : ctl_rxc;
  end
  assign wf = state_q == WAIT_FIRST;
  assign first = decode_data_vld_i && decode_head_vld_i;
  assign second = decode_data_vld_i && !wf && !decode_head_vld_i;
  always_comb begin
    state_d = decode_data_vld_i ? (decode_head_vld_i ? WAIT_SECOND : WAIT_FIRST) : state_q;
    half_d = first ? pd : half_q;
    head_d = first ? decode_head_i : head_q;
    vld_d = second;
    rxd_d = second ? (block_lock_i ? dec_rxd : XG_LF_W) : rxd_q;
    rxc_d = second ? (block_lock_i ? dec_rxc : 8'h11) : rxc_q;
    err_d = (decode_data_vld_i && (wf ^ decode_head_vld_i)) || (second && block_lock_i && dec_err);
    cnt_d = cnt_q + ERR_CNT_W'(err_d && !(&cnt_q));
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= WAIT_FIRST;
      half_q <= '0;
      head_q <= '0;
      rxd_q <= {8{XG_IDLE}};
      rxc_q <= 8'hFF;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      half_q <= half_d;
      head_q <= head_d;
      rxd_q <= rxd_d;
      rxc_q <= rxc_d;
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  assign xgmii_rxd_o = rxd_q;
  assign xgmii_rxc_o = rxc_q;
  assign xgmii_rxd_vld_o = vld_q;
  assign decode_err_o = err_q;
  assign err_cnt_o = cnt_q;
endmodule
